// File: rtl/sdio_pkg.sv
// Shared types and constants for the SDIO command sequencer.
//   state_e : sequencer states
//   phase_e : command phase. The encoding is also the value reported on err_phase_o.
//   Op*     : command indices the sequencer issues on its own (CMD55 prefix, CMD12 stop)
//   Rsp*    : response types for those commands
//   Stat*   : bit positions in the engine status word
package sdio_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StClr,
    StStart,
    StWait,
    StData,
    StDone
  } state_e;

  typedef enum logic [1:0] {
    PhMain = 2'd0,
    PhApp  = 2'd1,
    PhStop = 2'd2
  } phase_e;

  localparam logic [5:0] OpAppCmd  = 6'd55;
  localparam logic [5:0] OpStopTx  = 6'd12;

  localparam logic [2:0] RspAppCmd = 3'b001;
  localparam logic [2:0] RspStopTx = 3'b100;

  localparam int unsigned StatRspTimeout  = 0;
  localparam int unsigned StatRspCrc      = 1;
  localparam int unsigned StatBusyTimeout = 2;

  localparam logic [2:0] RetrySat = 3'd7;

endpackage

// File: rtl/sdio_cmd_seq.sv
// SDIO command sequencer. Accepts one request and drives the command engine through
// an optional CMD55 prefix, the main command and an optional CMD12 issued after the
// data path reports end of transfer. A single done_o pulse closes every accepted request.
//
// Ports
//   clk_i, rstn_i                 clock, asynchronous active-low reset
//   req_valid_i / req_ready_o     request handshake (ready only while idle)
//   req_op_i/arg_i/rsp_type_i     main command fields
//   req_app_i, req_stop_i         CMD55 prefix, CMD12 after data
//   req_rca_i                     card RCA for the CMD55 argument
//   data_eot_i                    data transfer finished (honoured only while waiting for data)
//   cmd_start_o, cmd_op_o, cmd_arg_o, cmd_rsp_type_o, clr_stat_o   to command engine
//   cmd_eot_i, cmd_status_i       from command engine
//   done_o, err_o, err_status_o, err_phase_o, retry_cnt_o           completion report
//
// Build option: define SDIO_CMD_RETRY_EN to retry commands that fail with a response
// timeout, up to RETRY_MAX times per command. Without it retry_cnt_o is tied to 0.
module sdio_cmd_seq
  import sdio_pkg::*;
#(
  parameter int unsigned RETRY_MAX = 3
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [5:0]  req_op_i,
  input  logic [31:0] req_arg_i,
  input  logic [2:0]  req_rsp_type_i,
  input  logic        req_app_i,
  input  logic        req_stop_i,
  input  logic [15:0] req_rca_i,
  input  logic        data_eot_i,
  output logic        cmd_start_o,
  output logic [5:0]  cmd_op_o,
  output logic [31:0] cmd_arg_o,
  output logic [2:0]  cmd_rsp_type_o,
  output logic        clr_stat_o,
  input  logic        cmd_eot_i,
  input  logic [5:0]  cmd_status_i,
  output logic        done_o,
  output logic        err_o,
  output logic [5:0]  err_status_o,
  output logic [1:0]  err_phase_o,
  output logic [2:0]  retry_cnt_o
);

`ifdef SDIO_CMD_RETRY_EN
  localparam bit RetryEn = 1'b1;
`else
  localparam bit RetryEn = 1'b0;
`endif

  state_e      state_q, state_d;
  phase_e      phase_q, phase_d;
  logic [5:0]  op_q, op_d;
  logic [31:0] arg_q, arg_d;
  logic [2:0]  rsp_q, rsp_d;
  logic        stop_q, stop_d;
  logic [15:0] rca_q, rca_d;
  logic        err_q, err_d;
  logic [5:0]  err_status_q, err_status_d;
  logic [1:0]  err_phase_q, err_phase_d;
  logic [2:0]  retry_q, retry_d;
  logic [2:0]  cmd_retry_q, cmd_retry_d;

  logic fail, retry_ok;

  // A hard failure arrives without eot. Upper status bits alongside eot also fail the
  // command, since only a clean or busy-timeout-only status counts as success.
  assign fail = cmd_status_i[StatRspTimeout] | cmd_status_i[StatRspCrc] |
                (cmd_eot_i & (|cmd_status_i[5:3]));
  assign retry_ok = RetryEn && cmd_status_i[StatRspTimeout] &&
                    (32'(cmd_retry_q) < RETRY_MAX);

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    op_d         = op_q;
    arg_d        = arg_q;
    rsp_d        = rsp_q;
    stop_d       = stop_q;
    rca_d        = rca_q;
    err_d        = err_q;
    err_status_d = err_status_q;
    err_phase_d  = err_phase_q;
    retry_d      = retry_q;
    cmd_retry_d  = cmd_retry_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          op_d         = req_op_i;
          arg_d        = req_arg_i;
          rsp_d        = req_rsp_type_i;
          stop_d       = req_stop_i;
          rca_d        = req_rca_i;
          phase_d      = req_app_i ? PhApp : PhMain;
          err_d        = 1'b0;
          err_status_d = '0;
          err_phase_d  = '0;
          retry_d      = '0;
          cmd_retry_d  = '0;
          state_d      = StClr;
        end
      end
      StClr:   state_d = StStart;
      StStart: state_d = StWait;
      StWait: begin
        if (fail) begin
          if (retry_ok) begin
            cmd_retry_d = cmd_retry_q + 3'd1;
            retry_d     = (retry_q == RetrySat) ? retry_q : retry_q + 3'd1;
            state_d     = StClr;
          end else begin
            err_d        = 1'b1;
            err_status_d = cmd_status_i;
            err_phase_d  = phase_q;
            state_d      = StDone;
          end
        end else if (cmd_eot_i) begin
          // Busy timeout is reported but does not stop the sequence.
          if (cmd_status_i[StatBusyTimeout]) begin
            err_d        = 1'b1;
            err_status_d = cmd_status_i;
            err_phase_d  = phase_q;
          end
          cmd_retry_d = '0;
          unique case (phase_q)
            PhApp: begin
              phase_d = PhMain;
              state_d = StClr;
            end
            PhMain:  state_d = stop_q ? StData : StDone;
            default: state_d = StDone;
          endcase
        end
      end
      StData: begin
        if (data_eot_i) begin
          phase_d     = PhStop;
          cmd_retry_d = '0;
          state_d     = StClr;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= StIdle;
      phase_q      <= PhMain;
      op_q         <= '0;
      arg_q        <= '0;
      rsp_q        <= '0;
      stop_q       <= 1'b0;
      rca_q        <= '0;
      err_q        <= 1'b0;
      err_status_q <= '0;
      err_phase_q  <= '0;
      retry_q      <= '0;
      cmd_retry_q  <= '0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      op_q         <= op_d;
      arg_q        <= arg_d;
      rsp_q        <= rsp_d;
      stop_q       <= stop_d;
      rca_q        <= rca_d;
      err_q        <= err_d;
      err_status_q <= err_status_d;
      err_phase_q  <= err_phase_d;
      retry_q      <= retry_d;
      cmd_retry_q  <= cmd_retry_d;
    end
  end

  // Command fields follow the phase register, so they stay stable from START through WAIT
  // and read as zero out of reset (phase MAIN, latched fields cleared).
  always_comb begin
    cmd_op_o       = op_q;
    cmd_arg_o      = arg_q;
    cmd_rsp_type_o = rsp_q;
    unique case (phase_q)
      PhApp: begin
        cmd_op_o       = OpAppCmd;
        cmd_arg_o      = {rca_q, 16'h0000};
        cmd_rsp_type_o = RspAppCmd;
      end
      PhStop: begin
        cmd_op_o       = OpStopTx;
        cmd_arg_o      = '0;
        cmd_rsp_type_o = RspStopTx;
      end
      default: ;
    endcase
  end

  assign req_ready_o  = (state_q == StIdle);
  assign clr_stat_o   = (state_q == StClr);
  assign cmd_start_o  = (state_q == StStart);
  assign done_o       = (state_q == StDone);
  assign err_o        = err_q;
  assign err_status_o = err_status_q;
  assign err_phase_o  = err_phase_q;
  assign retry_cnt_o  = RetryEn ? retry_q : 3'd0;

endmodule

// File: tb/tb_sdio_cmd_seq.sv
// Scoreboard bench for sdio_cmd_seq. A reference model turns each request plus a planned
// list of engine statuses into the expected command sequence and completion report; a
// responder plays the engine, and a monitor checks every start and done against the queues.
module tb_sdio_cmd_seq;

  localparam int RetryMax = 2;
`ifdef SDIO_CMD_RETRY_EN
  localparam bit RetryEn = 1'b1;
`else
  localparam bit RetryEn = 1'b0;
`endif

  typedef struct packed {
    logic [5:0]  op;
    logic [31:0] arg;
    logic [2:0]  rsp;
  } cmd_t;

  typedef struct packed {
    logic       err;
    logic [5:0] status;
    logic [1:0] phase;
    logic [2:0] retry;
  } res_t;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [5:0]  req_op_i = '0;
  logic [31:0] req_arg_i = '0;
  logic [2:0]  req_rsp_type_i = '0;
  logic        req_app_i = 1'b0;
  logic        req_stop_i = 1'b0;
  logic [15:0] req_rca_i = '0;
  logic        data_eot_i = 1'b0;
  logic        cmd_start_o;
  logic [5:0]  cmd_op_o;
  logic [31:0] cmd_arg_o;
  logic [2:0]  cmd_rsp_type_o;
  logic        clr_stat_o;
  logic        cmd_eot_i = 1'b0;
  logic [5:0]  cmd_status_i = '0;
  logic        done_o;
  logic        err_o;
  logic [5:0]  err_status_o;
  logic [1:0]  err_phase_o;
  logic [2:0]  retry_cnt_o;

  sdio_cmd_seq #(.RETRY_MAX(RetryMax)) dut (
    .clk_i          (clk_i),
    .rstn_i         (rstn_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_op_i       (req_op_i),
    .req_arg_i      (req_arg_i),
    .req_rsp_type_i (req_rsp_type_i),
    .req_app_i      (req_app_i),
    .req_stop_i     (req_stop_i),
    .req_rca_i      (req_rca_i),
    .data_eot_i     (data_eot_i),
    .cmd_start_o    (cmd_start_o),
    .cmd_op_o       (cmd_op_o),
    .cmd_arg_o      (cmd_arg_o),
    .cmd_rsp_type_o (cmd_rsp_type_o),
    .clr_stat_o     (clr_stat_o),
    .cmd_eot_i      (cmd_eot_i),
    .cmd_status_i   (cmd_status_i),
    .done_o         (done_o),
    .err_o          (err_o),
    .err_status_o   (err_status_o),
    .err_phase_o    (err_phase_o),
    .retry_cnt_o    (retry_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int   n_tests = 0;
  int   n_fail = 0;
  cmd_t exp_cmd_q[$];
  res_t exp_res_q[$];
  logic [5:0] plan_st[$];
  int   plan_dly[$];
  bit   plan_data[$];
  int   plan_ddly[$];
  logic [5:0] st_in[$];
  int   dly_in[$];
  bit   auto_resp = 1'b1;
  int   done_cnt = 0;
  bit   clr_seen = 1'b0;
  res_t last_res = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic finish_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  endtask

  // Reference model: walk the phases, consuming one planned status per command attempt.
  task automatic model(input logic [5:0] op, input logic [31:0] arg, input logic [2:0] rsp,
                       input bit app, input bit stop, input logic [15:0] rca,
                       input int ddly, output res_t r);
    int ph;  // 0 main, 1 app, 2 stop
    int k, rcmd, rtot;
    bit fin;
    cmd_t c;
    logic [5:0] s;
    r = '0; k = 0; rcmd = 0; rtot = 0; fin = 1'b0;
    ph = app ? 1 : 0;
    while (!fin) begin
      if (ph == 1) begin
        c.op = 6'd55; c.arg = {rca, 16'h0000}; c.rsp = 3'b001;
      end else if (ph == 2) begin
        c.op = 6'd12; c.arg = 32'h0; c.rsp = 3'b100;
      end else begin
        c.op = op; c.arg = arg; c.rsp = rsp;
      end
      exp_cmd_q.push_back(c);
      s = (k < st_in.size()) ? st_in[k] : 6'd0;
      plan_st.push_back(s);
      plan_dly.push_back((k < dly_in.size()) ? dly_in[k] : 1 + int'($urandom_range(0, 15)));
      plan_ddly.push_back(ddly);
      k++;
      if (s[0] || s[1]) begin
        plan_data.push_back(1'b0);
        if (RetryEn && s[0] && rcmd < RetryMax) begin
          rcmd++;
          if (rtot < 7) rtot++;
        end else begin
          r.err = 1'b1; r.status = s; r.phase = 2'(ph); fin = 1'b1;
        end
      end else begin
        if (s[2]) begin
          r.err = 1'b1; r.status = s; r.phase = 2'(ph);
        end
        plan_data.push_back(ph == 0 && stop);
        rcmd = 0;
        if (ph == 1) ph = 0;
        else if (ph == 0 && stop) ph = 2;
        else fin = 1'b1;
      end
    end
    r.retry = RetryEn ? 3'(rtot) : 3'd0;
    exp_res_q.push_back(r);
    st_in.delete();
    dly_in.delete();
  endtask

  task automatic issue(input logic [5:0] op, input logic [31:0] arg, input logic [2:0] rsp,
                       input bit app, input bit stop, input logic [15:0] rca, input int ddly);
    int t, d0;
    res_t r;
    model(op, arg, rsp, app, stop, rca, ddly, r);
    @(posedge clk_i); #1;
    check("err_held", 64'(err_o), 64'(last_res.err));
    check("err_status_held", 64'(err_status_o), 64'(last_res.status));
    req_op_i = op; req_arg_i = arg; req_rsp_type_i = rsp;
    req_app_i = app; req_stop_i = stop; req_rca_i = rca;
    req_valid_i = 1'b1;
    t = 0;
    do begin @(negedge clk_i); t++; end while (!req_ready_o && t < 100);
    if (!req_ready_o) begin
      n_tests++; n_fail++;
      $display("FAIL accept_timeout: got ready 0, expected ready 1");
      finish_run();
    end
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    // Scramble the fields so only latched values can reach the engine.
    req_op_i = 6'($urandom); req_arg_i = $urandom; req_rsp_type_i = 3'($urandom);
    req_rca_i = 16'($urandom);
    @(negedge clk_i);
    check("ready_busy", 64'(req_ready_o), 64'd0);
    d0 = done_cnt; t = 0;
    while (done_cnt == d0 && t < 5000) begin @(negedge clk_i); t++; end
    if (done_cnt == d0) begin
      n_tests++; n_fail++;
      $display("FAIL done_timeout: got no done_o, expected done_o");
      finish_run();
    end
    last_res = r;
  endtask

  // Monitor
  initial begin
    cmd_t e;
    res_t r;
    forever begin
      @(negedge clk_i);
      if (rstn_i) begin
        if (cmd_start_o) begin
          check("clr_before_start", 64'(clr_seen), 64'd1);
          clr_seen = 1'b0;
          if (exp_cmd_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_start: got op %0d, expected no command", cmd_op_o);
          end else begin
            e = exp_cmd_q.pop_front();
            check("cmd_op", 64'(cmd_op_o), 64'(e.op));
            check("cmd_arg", 64'(cmd_arg_o), 64'(e.arg));
            check("cmd_rsp", 64'(cmd_rsp_type_o), 64'(e.rsp));
          end
        end
        if (clr_stat_o) clr_seen = 1'b1;
        if (done_o) begin
          done_cnt++;
          if (exp_res_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_done: got done_o 1, expected 0");
          end else begin
            r = exp_res_q.pop_front();
            check("err", 64'(err_o), 64'(r.err));
            check("err_status", 64'(err_status_o), 64'(r.status));
            check("err_phase", 64'(err_phase_o), 64'(r.phase));
            check("retry_cnt", 64'(retry_cnt_o), 64'(r.retry));
            check("cmds_left", 64'(exp_cmd_q.size()), 64'd0);
          end
        end
      end
    end
  end

  // Command engine / data path responder
  initial begin
    logic [5:0] s;
    int dly, ddly;
    bit dat;
    forever begin
      @(negedge clk_i);
      if (auto_resp && rstn_i && cmd_start_o) begin
        if (plan_st.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL resp_plan: got start with empty plan, expected none");
        end else begin
          s = plan_st.pop_front(); dly = plan_dly.pop_front();
          dat = plan_data.pop_front(); ddly = plan_ddly.pop_front();
          repeat (dly) @(negedge clk_i);
          cmd_status_i = s;
          // Failures sometimes arrive with eot to exercise precedence.
          cmd_eot_i = (s[1:0] == 2'b00) ? 1'b1 : 1'($urandom_range(0, 1));
          @(negedge clk_i);
          cmd_status_i = '0; cmd_eot_i = 1'b0;
          if (dat) begin
            repeat (ddly) @(negedge clk_i);
            data_eot_i = 1'b1;
            @(negedge clk_i);
            data_eot_i = 1'b0;
          end
        end
      end
    end
  end

  // Stimulus
  initial begin
    int t, d0;
    cmd_t c;
    repeat (3) @(negedge clk_i);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_start", 64'(cmd_start_o), 64'd0);
    check("rst_clr", 64'(clr_stat_o), 64'd0);
    check("rst_cmd", 64'({cmd_op_o, cmd_arg_o, cmd_rsp_type_o}), 64'd0);
    check("rst_err", 64'({err_o, err_status_o, err_phase_o}), 64'd0);
    check("rst_retry", 64'(retry_cnt_o), 64'd0);
    rstn_i = 1'b1;
    @(negedge clk_i);
    check("ready_after_rst", 64'(req_ready_o), 64'd1);

    // Stray data_eot while idle must be ignored.
    data_eot_i = 1'b1; @(negedge clk_i); data_eot_i = 1'b0;

    // Plain command, late eot
    dly_in.push_back(50);
    issue(6'd17, 32'h200, 3'd1, 1'b0, 1'b0, 16'h0, 0);
    // CMD55 prefix then CMD41
    issue(6'd41, 32'h40ff8000, 3'd3, 1'b1, 1'b0, 16'h1234, 0);
    // Data transfer followed by CMD12
    issue(6'd18, 32'h1000, 3'd1, 1'b0, 1'b1, 16'h0, 200);
    // CRC error in APP phase stops the sequence
    st_in.push_back(6'b000010);
    issue(6'd41, 32'h0, 3'd3, 1'b1, 1'b0, 16'h5678, 0);
    // Repeated response timeouts
    st_in.push_back(6'd1); st_in.push_back(6'd1); st_in.push_back(6'd1);
    issue(6'd7, 32'hdead0000, 3'd1, 1'b0, 1'b0, 16'h0, 0);
    // Busy timeout on main command: reported, sequence still goes through CMD12
    st_in.push_back(6'b000100);
    issue(6'd25, 32'h80, 3'd5, 1'b0, 1'b1, 16'h0, 5);

    // Reset while waiting for data
    auto_resp = 1'b0;
    c.op = 6'd18; c.arg = 32'h300; c.rsp = 3'd1;
    exp_cmd_q.push_back(c);
    @(posedge clk_i); #1;
    req_op_i = 6'd18; req_arg_i = 32'h300; req_rsp_type_i = 3'd1;
    req_app_i = 1'b0; req_stop_i = 1'b1; req_valid_i = 1'b1;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    t = 0;
    do begin @(negedge clk_i); t++; end while (!cmd_start_o && t < 50);
    check("rst_test_start", 64'(cmd_start_o), 64'd1);
    @(negedge clk_i);
    cmd_eot_i = 1'b1;
    @(negedge clk_i);
    cmd_eot_i = 1'b0;
    repeat (10) @(negedge clk_i);
    check("in_data_not_ready", 64'(req_ready_o), 64'd0);
    d0 = done_cnt;
    #2 rstn_i = 1'b0;
    #1;
    check("async_rst_ready", 64'(req_ready_o), 64'd1);
    @(negedge clk_i);
    rstn_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check("post_rst_ready", 64'(req_ready_o), 64'd1);
    check("post_rst_no_done", 64'(done_cnt), 64'(d0));
    check("post_rst_err", 64'(err_o), 64'd0);
    exp_cmd_q.delete();
    clr_seen = 1'b0;
    last_res = '0;
    auto_resp = 1'b1;
    issue(6'd17, 32'h400, 3'd1, 1'b0, 1'b0, 16'h0, 0);

    // Randomised requests
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 8; i++) begin
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 6) st_in.push_back(6'd0);
        else if (r == 6) st_in.push_back(6'd4);
        else if (r == 7) st_in.push_back(6'd1);
        else if (r == 8) st_in.push_back(6'd2);
        else st_in.push_back(6'd3);
      end
      issue(6'($urandom), $urandom, 3'($urandom), ($urandom_range(0, 9) < 3),
            ($urandom_range(0, 9) < 3), 16'($urandom), int'($urandom_range(0, 30)));
    end

    repeat (5) @(negedge clk_i);
    check("final_cmd_q_empty", 64'(exp_cmd_q.size()), 64'd0);
    check("final_res_q_empty", 64'(exp_res_q.size()), 64'd0);
    finish_run();
  end

endmodule
